cpu_controller: RTL and testbench

- Sequences the VeriRISC datapath through a fixed 8-phase instruction cycle.
- Decodes the 3-bit opcode and the accumulator zero flag into one-hot-ish control strobes:
  - PC: ld_pc, inc_pc
  - IR load, memory rd/wr, address mux sel, data bus enable, accumulator load
- Sits between the instruction register/ALU and the program counter/memory/accumulator.
- Owns the sticky halt state.

---
 rtl/veririsc_pkg.sv | 35 +++
 rtl/cpu_controller.sv | 104 ++++++++++
 tb/tb_cpu_controller.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/veririsc_pkg.sv
// Shared VeriRISC types: instruction-cycle phases and opcodes.
package veririsc_pkg;

    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = $clog2(NUM_PHASES);
    localparam int OPCODE_W   = 3;

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    typedef enum logic [OPCODE_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// VeriRISC controller: 8-phase sequencer, strobe decode and sticky halt.
module cpu_controller
    import veririsc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                wr,
    output logic                data_e,
    output logic [PHASE_W-1:0]  phase
);

    phase_t phase_q, phase_nxt;
    logic   halted_q, halted_nxt;
    logic   aluop;

    assign aluop = is_aluop(opcode);
    assign phase = phase_q;

    // Phase counter and halted flag; reset aborts any instruction or halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_nxt;
            halted_q <= halted_nxt;
        end
    end

    // Next state: step every cycle, freeze at OP_ADDR once HLT is seen there.
    always_comb begin
        phase_nxt  = phase_q;
        halted_nxt = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && opcode == HLT)
                halted_nxt = 1'b1;
            else
                phase_nxt = phase_t'(phase_q + 3'd1);
        end
    end

    // Strobe decode; opcode is only consulted from OP_ADDR onward so a
    // changing or unknown opcode during fetch cannot reach the outputs.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        halt   = 1'b0;
        inc_pc = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: reference model feeds a queue of
// expected output words, popped and compared on each falling edge.
module tb_cpu_controller;
    import veririsc_pkg::*;

    logic                clk;
    logic                rst;
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [PHASE_W-1:0]  phase;

    cpu_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
        .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e,phase}
    logic [11:0] exp_q[$];
    logic [11:0] obs;
    assign obs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase};

    localparam logic [11:0] RST_WORD = 12'b1_0000_0000_000;

    // Model state
    int   m_ph;
    bit   m_hlt;
    logic [2:0] m_op;
    logic m_z;

    task automatic chk(input string tag, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b want %b (ph=%0d op=%0d)", tag, act, exp, m_ph, m_op);
        end
    endtask

    function automatic logic [11:0] model(input int ph, input bit hl,
                                          input logic [2:0] op, input logic z);
        logic e_sel, e_rd, e_ir, e_h, e_inc, e_ac, e_pc, e_wr, e_de, alu;
        alu   = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        if (hl) return {1'b0, 1'b0, 1'b0, 1'b1, 5'b0, 3'd4};
        e_sel = (ph <= 3);
        e_rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        e_ir  = (ph == 2) || (ph == 3);
        e_h   = (ph == 4) && (op == 3'd0);
        e_inc = (ph == 4) || (ph == 6 && op == 3'd1 && z);
        e_ac  = (ph == 7) && alu;
        e_pc  = (ph >= 6) && (op == 3'd7);
        e_wr  = (ph == 7) && (op == 3'd6);
        e_de  = (ph >= 6) && (op == 3'd6);
        return {e_sel, e_rd, e_ir, e_h, e_inc, e_ac, e_pc, e_wr, e_de, 3'(ph)};
    endfunction

    // One clock: advance model across the edge, then drive new inputs and
    // queue what the outputs must be for the coming cycle.
    task automatic cyc(input logic [2:0] op, input logic z);
        @(posedge clk);
        if (!m_hlt) begin
            if (m_ph == 4 && m_op == 3'd0) m_hlt = 1'b1;
            else m_ph = (m_ph + 1) % NUM_PHASES;
        end
        #1;
        opcode = op; zero = z;
        m_op = op; m_z = z;
        exp_q.push_back(model(m_ph, m_hlt, m_op, m_z));
    endtask

    task automatic instr(input logic [2:0] op, input logic z);
        for (int i = 0; i < NUM_PHASES; i++) cyc(op, z);
    endtask

    // Asynchronous reset pulse placed just after a falling edge.
    task automatic rst_pulse(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk({tag, "_async"}, obs, RST_WORD);
        opcode = 3'bx; zero = 1'bx;
        @(posedge clk);
        #1 chk({tag, "_hold"}, obs, RST_WORD);
        @(negedge clk);
        #2 rst = 1'b1;
        m_ph = 0; m_hlt = 1'b0;
        #1 chk({tag, "_rel"}, obs, RST_WORD);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (exp_q.size() > 0) chk("cyc", obs, exp_q.pop_front());
    end

    initial begin
        rst = 1'b0; opcode = 3'bx; zero = 1'bx;
        m_ph = 0; m_hlt = 1'b0; m_op = 3'd0; m_z = 1'b0;
        #3 chk("por", obs, RST_WORD);
        rst_pulse("rst0");

        // Full instructions through every opcode except HLT
        instr(3'd5, 1'b0);   // LDA
        instr(3'd6, 1'b0);   // STO
        instr(3'd1, 1'b1);   // SKZ taken
        instr(3'd1, 1'b0);   // SKZ not taken
        instr(3'd7, 1'b1);   // JMP
        instr(3'd2, 1'b0);   // ADD
        instr(3'd3, 1'b1);   // AND
        instr(3'd4, 1'b0);   // XOR

        // Abort mid-instruction at OP_FETCH
        for (int i = 0; i < 5; i++) cyc(3'd5, 1'b0);
        if (m_ph != 5) $display("note: model phase %0d before mid reset", m_ph);
        rst_pulse("rst_mid");
        instr(3'd6, 1'b1);

        // HLT, then hammer opcode/zero while halted
        instr(3'd0, 1'b0);
        for (int i = 0; i < 24; i++)
            cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        rst_pulse("rst_hlt");

        // Normal stepping resumes after reset
        instr(3'd7, 1'b0);
        instr(3'd1, 1'b1);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) chk("drain", 12'(exp_q.size()), 12'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
